// File: rtl/demux_deser.sv
// demux_deser: serial-to-parallel receiver feeding a 1-to-2 demultiplexer.
// A WIDTH-bit word arrives LSB first after a start strobe and is delivered
// to dout0/dout1 (chosen by sel at the start edge) with a valid/ready handshake.
// Optional feature macro: DEMUX_DESER_PARITY_EN adds one even-parity bit after
// the data and drives par_err; without it par_err is tied low.
module demux_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  input  logic             sel,
  input  logic             ready,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic             valid0,
  output logic             valid1,
  output logic             busy,
  output logic             par_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DEMUX_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, HOLD = 2'd3} state_t;

  // Even parity check: high when data bits plus parity bit have odd weight.
  function automatic logic parity_error(input logic [WIDTH-1:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd3} state_t;
`endif

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] shreg_r;
  logic             chan_r;
  logic             last_s;
  logic             deliver_s;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] deliver_word_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode, word assembly and delivery strobe.
  always_comb begin
    state_s   = state_r;
    deliver_s = 1'b0;
    last_s    = (count_r == LAST);
    word_s    = shreg_r;
    word_s[count_r] = din;
    case (state_r)
      IDLE: begin
        if (start) state_s = SHIFT;
        else       state_s = IDLE;
      end
      SHIFT: begin
        if (last_s) begin
`ifdef DEMUX_DESER_PARITY_EN
          state_s = PAR;
`else
          state_s   = HOLD;
          deliver_s = 1'b1;
`endif
        end else begin
          state_s = SHIFT;
        end
      end
`ifdef DEMUX_DESER_PARITY_EN
      PAR: begin
        state_s   = HOLD;
        deliver_s = 1'b1;
      end
`endif
      HOLD: begin
        if (ready) state_s = IDLE;
        else       state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
`ifdef DEMUX_DESER_PARITY_EN
    // Every data bit is already in the shift register by the parity cycle.
    deliver_word_s = shreg_r;
`else
    // The last data bit is delivered straight from din on its own edge.
    deliver_word_s = word_s;
`endif
  end

  // Shift register, bit counter and channel latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
      shreg_r <= {WIDTH{1'b0}};
      chan_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            chan_r  <= sel;
            count_r <= {CW{1'b0}};
          end
        end
        SHIFT: begin
          shreg_r <= word_s;
          if (last_s) count_r <= {CW{1'b0}};
          else        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: channel words, valid flags and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout0  <= {WIDTH{1'b0}};
      dout1  <= {WIDTH{1'b0}};
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      busy   <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      if (deliver_s) begin
        if (chan_r) begin
          dout1  <= deliver_word_s;
          valid1 <= 1'b1;
        end else begin
          dout0  <= deliver_word_s;
          valid0 <= 1'b1;
        end
      end else if (state_r == HOLD && ready) begin
        if (chan_r) valid1 <= 1'b0;
        else        valid0 <= 1'b0;
      end
    end
  end

`ifdef DEMUX_DESER_PARITY_EN
  // Parity error flag, set with valid and cleared on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (deliver_s) begin
      par_err <= parity_error(shreg_r, din);
    end else if (state_r == HOLD && ready) begin
      par_err <= 1'b0;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_deser.sv
// Directed testbench for demux_deser (WIDTH = 8). Inputs change on the falling
// edge and outputs are checked on the falling edge, away from the active edge.
module tb_demux_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       din;
  logic       sel;
  logic       ready;
  logic [7:0] dout0;
  logic [7:0] dout1;
  logic       valid0;
  logic       valid1;
  logic       busy;
  logic       par_err;

  int n_vec = 0;
  int n_err = 0;

  demux_deser #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .din    (din),
    .sel    (sel),
    .ready  (ready),
    .dout0  (dout0),
    .dout1  (dout1),
    .valid0 (valid0),
    .valid1 (valid1),
    .busy   (busy),
    .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one frame starting at a falling edge; returns at the falling edge
  // just after the delivery edge. With noise, start pulses and sel flips
  // during the data bits, which the DUT must ignore.
  task automatic frame(input logic s, input logic [7:0] w, input logic pbit, input logic noise);
    start = 1'b1;
    sel   = s;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = w[i];
      if (noise) begin
        start = 1'b1;
        sel   = ~s;
      end
      @(negedge clk);
      if (i == 3) check_eq("busy_mid_frame", {31'd0, busy}, 32'd1);
    end
`ifdef DEMUX_DESER_PARITY_EN
    din = pbit;
    @(negedge clk);
`endif
    din   = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    din   = 1'b0;
    sel   = 1'b0;
    ready = 1'b1;
    #2;
    check_eq("rst_dout0",  {24'd0, dout0}, 32'h00);
    check_eq("rst_dout1",  {24'd0, dout1}, 32'h00);
    check_eq("rst_valids", {30'd0, valid1, valid0}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy}, 32'd0);
    check_eq("rst_par_err",{31'd0, par_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ch0 delivery with ready high: valid0 for exactly one cycle.
    frame(1'b0, 8'hA5, 1'b0, 1'b0);
    check_eq("t1_valid0", {31'd0, valid0}, 32'd1);
    check_eq("t1_dout0",  {24'd0, dout0}, 32'hA5);
    check_eq("t1_dout1",  {24'd0, dout1}, 32'h00);
    check_eq("t1_valid1", {31'd0, valid1}, 32'd0);
    check_eq("t1_busy",   {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("t1_valid0_drop", {31'd0, valid0}, 32'd0);
    check_eq("t1_busy_drop",   {31'd0, busy}, 32'd0);
    check_eq("t1_dout0_keep",  {24'd0, dout0}, 32'hA5);

    // Backpressure on ch1, with start/sel noise while holding.
    ready = 1'b0;
    frame(1'b1, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_valid1_hold", {31'd0, valid1}, 32'd1);
      check_eq("t2_dout1_hold",  {24'd0, dout1}, 32'h3C);
      check_eq("t2_busy_hold",   {31'd0, busy}, 32'd1);
      start = 1'b1;
      sel   = k[0];
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check_eq("t2_valid1_drop", {31'd0, valid1}, 32'd0);
    check_eq("t2_busy_drop",   {31'd0, busy}, 32'd0);
    check_eq("t2_dout1_keep",  {24'd0, dout1}, 32'h3C);
    check_eq("t2_dout0_keep",  {24'd0, dout0}, 32'hA5);
    @(negedge clk);
    check_eq("t2_no_extra",    {31'd0, busy}, 32'd0);

    // Ignored start/sel during SHIFT: word goes to ch0 as latched.
    frame(1'b0, 8'h5A, 1'b0, 1'b1);
    check_eq("t3_dout0",  {24'd0, dout0}, 32'h5A);
    check_eq("t3_valid0", {31'd0, valid0}, 32'd1);
    check_eq("t3_valid1", {31'd0, valid1}, 32'd0);
    check_eq("t3_dout1",  {24'd0, dout1}, 32'h3C);
    @(negedge clk);
    @(negedge clk);
    check_eq("t3_no_extra", {31'd0, busy}, 32'd0);

    // Reset after 4 data bits: outputs clear without a clock edge.
    start = 1'b1;
    sel   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_eq("t4_dout0", {24'd0, dout0}, 32'h00);
    check_eq("t4_dout1", {24'd0, dout1}, 32'h00);
    check_eq("t4_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 1'b0;
    frame(1'b0, 8'hFF, 1'b0, 1'b0);
    check_eq("t4_dout0_ff", {24'd0, dout0}, 32'hFF);
    check_eq("t4_valid0",   {31'd0, valid0}, 32'd1);
    @(negedge clk);

    // Back-to-back frames at minimum period.
    frame(1'b0, 8'h01, 1'b0, 1'b0);
    check_eq("t5_dout0", {24'd0, dout0}, 32'h01);
    @(negedge clk);
    frame(1'b1, 8'h80, 1'b0, 1'b0);
    check_eq("t5_dout1",   {24'd0, dout1}, 32'h80);
    check_eq("t5_valid1",  {31'd0, valid1}, 32'd1);
    check_eq("t5_dout0_keep", {24'd0, dout0}, 32'h01);
    @(negedge clk);
    check_eq("t5_valid1_drop", {31'd0, valid1}, 32'd0);
    check_eq("t5_dout1_keep",  {24'd0, dout1}, 32'h80);

`ifdef DEMUX_DESER_PARITY_EN
    // Parity: 0xA5 has even weight, so parity bit 0 is correct.
    frame(1'b0, 8'hA5, 1'b0, 1'b0);
    check_eq("t6_par_ok",  {31'd0, par_err}, 32'd0);
    check_eq("t6_valid0",  {31'd0, valid0}, 32'd1);
    @(negedge clk);
    frame(1'b0, 8'hA5, 1'b1, 1'b0);
    check_eq("t6_par_bad", {31'd0, par_err}, 32'd1);
    check_eq("t6_dout0",   {24'd0, dout0}, 32'hA5);
    @(negedge clk);
    check_eq("t6_par_clr", {31'd0, par_err}, 32'd0);
`else
    check_eq("t6_par_tied", {31'd0, par_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
